// File: rtl/cpu_core_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_core_mc                                                |
// | Description : multi-cycle accumulator CPU with req/ack program and data  |
// |               memory ports; optional CPU_PERF_CNT_EN perf counters.       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module cpu_core_mc #(
   parameter int DW   = 8,
   parameter int AW   = 8,
   parameter int NREG = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] user_in,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [15:0]   imem_data,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [9:0]    dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic          dmem_ack,
   input  logic [DW-1:0] dmem_rdata,
   output logic [DW-1:0] acc_out,
   output logic          flag_cy,
   output logic [AW-1:0] pc_out,
`ifdef CPU_PERF_CNT_EN
   output logic [31:0]   cyc_cnt,
   output logic [31:0]   instret,
`endif
   output logic          halted
);

   localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

   localparam logic [2:0] c_cls_alu_imm = 3'b000;
   localparam logic [2:0] c_cls_alu_reg = 3'b001;
   localparam logic [2:0] c_cls_alu_mem = 3'b010;
   localparam logic [2:0] c_cls_st_reg  = 3'b011;
   localparam logic [2:0] c_cls_st_mem  = 3'b100;
   localparam logic [2:0] c_cls_jmp     = 3'b101;
   localparam logic [2:0] c_cls_bank    = 3'b110;
   localparam logic [2:0] c_cls_halt    = 3'b111;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEM   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   logic [AW-1:0]          r_pc;
   logic [DW-1:0]          r_acc;
   logic                   r_cy, r_ov;
   logic [1:0]             r_bank;
   logic [15:0]            r_ir;
   logic [9:0]             r_daddr;
   logic                   r_dwe;
   logic [DW-1:0]          r_dwdata;

   logic [2:0]             w_cls, w_fn;
   logic [IW-1:0]          w_idx;
   logic [DW-1:0]          w_imm, w_rd, w_alu_b, w_res;
   logic [DW:0]            w_sum;
   logic                   w_cy, w_ov, w_z, w_s, w_taken, w_reg_we;
   logic [AW-1:0]          w_pc_inc;
   logic [NREG-1:0][DW-1:0] w_rf;
   logic                   w_unused_ir;

   assign w_cls       = r_ir[15:13];
   assign w_fn        = r_ir[12:10];
   assign w_idx       = r_ir[IW-1:0];
   assign w_imm       = DW'(r_ir[7:0]);
   assign w_unused_ir = ^r_ir[9:8];
   assign w_pc_inc    = r_pc + AW'(1);
   assign w_z         = (r_acc == '0);
   assign w_s         = r_acc[DW-1];

   // Top register entry is the user-input port: read-only, never stored.
   assign w_rf[NREG-1] = user_in;
   assign w_rd         = w_rf[w_idx];
   assign w_reg_we     = (r_state == S_EXEC) && (w_cls == c_cls_st_reg);

   genvar gi;
   generate
      for (gi = 0; gi < NREG-1; gi++) begin : g_reg
         logic [DW-1:0] r_q;
         always_ff @(posedge clk) begin
            if (rst)
               r_q <= '0;
            else if (w_reg_we && (w_idx == IW'(gi)))
               r_q <= r_acc;
         end
         assign w_rf[gi] = r_q;
      end
   endgenerate

   always_comb begin
      if (r_state == S_MEM)
         w_alu_b = dmem_rdata;
      else if (w_cls == c_cls_alu_imm)
         w_alu_b = w_imm;
      else
         w_alu_b = w_rd;
   end

   always_comb begin
      w_sum = '0;
      w_res = r_acc;
      w_cy  = r_cy;
      w_ov  = r_ov;
      case (w_fn)
         3'b000: w_res = w_alu_b;
         3'b001: begin
            w_sum = {1'b0, r_acc} + {1'b0, w_alu_b};
            w_res = w_sum[DW-1:0];
            w_cy  = w_sum[DW];
            w_ov  = (r_acc[DW-1] == w_alu_b[DW-1]) && (w_res[DW-1] != r_acc[DW-1]);
         end
         3'b010: begin
            w_sum = {1'b0, r_acc} + {1'b0, w_alu_b} + {{DW{1'b0}}, r_cy};
            w_res = w_sum[DW-1:0];
            w_cy  = w_sum[DW];
            w_ov  = (r_acc[DW-1] == w_alu_b[DW-1]) && (w_res[DW-1] != r_acc[DW-1]);
         end
         3'b011: begin
            // Bit DW of the widened difference is the borrow.
            w_sum = {1'b0, r_acc} - {1'b0, w_alu_b};
            w_res = w_sum[DW-1:0];
            w_cy  = w_sum[DW];
            w_ov  = (r_acc[DW-1] != w_alu_b[DW-1]) && (w_res[DW-1] != r_acc[DW-1]);
         end
         3'b100: w_res = r_acc & w_alu_b;
         3'b101: w_res = r_acc | w_alu_b;
         3'b110: w_res = r_acc ^ w_alu_b;
         default: w_res = ~w_alu_b;
      endcase
   end

   always_comb begin
      case (w_fn)
         3'b000: w_taken = 1'b1;
         3'b001: w_taken = w_z;
         3'b010: w_taken = !w_z;
         3'b011: w_taken = w_s;
         3'b100: w_taken = !w_s;
         3'b101: w_taken = r_ov;
         3'b110: w_taken = r_cy;
         default: w_taken = !r_cy;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_FETCH;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      case (r_state)
         S_FETCH: begin
            imem_req = !rst;
            if (imem_ack)
               w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (w_cls == c_cls_halt)
               w_state_nxt = S_HALT;
            else if ((w_cls == c_cls_alu_mem) || (w_cls == c_cls_st_mem))
               w_state_nxt = S_MEM;
            else
               w_state_nxt = S_FETCH;
         end
         S_MEM: begin
            dmem_req = !rst;
            if (dmem_ack)
               w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= '0;
         r_acc    <= '0;
         r_cy     <= 1'b0;
         r_ov     <= 1'b0;
         r_bank   <= 2'b00;
         r_ir     <= '0;
         r_daddr  <= '0;
         r_dwe    <= 1'b0;
         r_dwdata <= '0;
      end else begin
         case (r_state)
            S_FETCH: if (imem_ack) r_ir <= imem_data;
            S_EXEC: begin
               case (w_cls)
                  c_cls_alu_imm, c_cls_alu_reg: begin
                     r_acc <= w_res;
                     r_cy  <= w_cy;
                     r_ov  <= w_ov;
                     r_pc  <= w_pc_inc;
                  end
                  c_cls_st_reg: r_pc <= w_pc_inc;
                  c_cls_jmp:    r_pc <= w_taken ? r_ir[AW-1:0] : w_pc_inc;
                  c_cls_bank: begin
                     r_bank <= r_ir[1:0];
                     r_pc   <= w_pc_inc;
                  end
                  c_cls_alu_mem, c_cls_st_mem: begin
                     r_daddr  <= {r_bank, w_rd[7:0]};
                     r_dwe    <= (w_cls == c_cls_st_mem);
                     r_dwdata <= r_acc;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               if (dmem_ack) begin
                  if (!r_dwe) begin
                     r_acc <= w_res;
                     r_cy  <= w_cy;
                     r_ov  <= w_ov;
                  end
                  r_pc <= w_pc_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_addr  = r_pc;
   assign dmem_addr  = r_daddr;
   assign dmem_we    = r_dwe;
   assign dmem_wdata = r_dwdata;
   assign acc_out    = r_acc;
   assign flag_cy    = r_cy;
   assign pc_out     = r_pc;
   assign halted     = (r_state == S_HALT);

`ifdef CPU_PERF_CNT_EN
   logic [31:0] r_cyc_cnt, r_instret;
   logic        w_retire;

   assign w_retire = ((r_state == S_EXEC) && (w_cls != c_cls_alu_mem) &&
                      (w_cls != c_cls_st_mem) && (w_cls != c_cls_halt)) ||
                     ((r_state == S_MEM) && dmem_ack);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cyc_cnt <= '0;
         r_instret <= '0;
      end else begin
         if (r_state != S_HALT)
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
         if (w_retire)
            r_instret <= r_instret + 32'd1;
      end
   end

   assign cyc_cnt = r_cyc_cnt;
   assign instret = r_instret;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_core_mc                                             |
// | Description : program-driven bench for cpu_core_mc with wait-state mems. |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_cpu_core_mc;
   localparam int DW = 8, AW = 8, NREG = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] user_in = 8'hC3;
   logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, flag_cy, halted;
   logic [AW-1:0] imem_addr, pc_out;
   logic [15:0]   imem_data;
   logic [9:0]    dmem_addr;
   logic [DW-1:0] dmem_wdata, dmem_rdata, acc_out;
`ifdef CPU_PERF_CNT_EN
   logic [31:0]   cyc_cnt, instret;
`endif

   logic [15:0]   imem [256];
   logic [DW-1:0] dmem [1024];
   int            imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;
   logic          imem_hold = 1'b0;
   int            n_vec = 0, n_err = 0;

   cpu_core_mc #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
      .clk(clk), .rst(rst), .user_in(user_in),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .acc_out(acc_out), .flag_cy(flag_cy), .pc_out(pc_out),
`ifdef CPU_PERF_CNT_EN
      .cyc_cnt(cyc_cnt), .instret(instret),
`endif
      .halted(halted)
   );

   always #5 clk = ~clk;

   // Memories acknowledge after a programmable number of wait cycles.
   assign imem_ack   = imem_req && !imem_hold && (icnt == imem_wait);
   assign imem_data  = imem[imem_addr];
   assign dmem_ack   = dmem_req && (dcnt == dmem_wait);
   assign dmem_rdata = dmem[dmem_addr];

   always @(posedge clk) begin
      icnt <= (rst || !imem_req || imem_ack) ? 0 : icnt + 1;
      dcnt <= (rst || !dmem_req || dmem_ack) ? 0 : dcnt + 1;
      if (rst)
         for (int i = 0; i < 1024; i++) dmem[i] <= '0;
      else if (dmem_req && dmem_we && dmem_ack)
         dmem[dmem_addr] <= dmem_wdata;
   end

   typedef struct {
      logic [15:0] i0, i1, i2;
      logic [7:0]  acc;
      logic        cy;
      logic [7:0]  pc;
   } vec_t;

   typedef struct {
      logic [7:0] acc;
      logic       cy;
      logic [7:0] pc;
   } exp_t;

   vec_t vecs[13];
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) imem[i] = 16'hE000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_halt(input string name);
      for (int c = 0; c < 300 && !halted; c++) @(negedge clk);
      check({name, "_halted"}, {31'b0, halted}, 32'd1);
   endtask

   task automatic wait_pc(input logic [7:0] pc, input logic eq, input string name);
      int c;
      for (c = 0; c < 300; c++) begin
         @(negedge clk);
         if ((pc_out == pc) == eq) break;
      end
      check({name, "_pc_reached"}, {31'b0, (pc_out == pc) == eq}, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: sim time expired, finished=0 expected 1");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   wr_cyc, rq_cyc, bad;

      vecs[0]  = '{16'h00FF, 16'h0401, 16'hA420, 8'h00, 1'b1, 8'h20};
      vecs[1]  = '{16'h00FF, 16'h0401, 16'hA820, 8'h00, 1'b1, 8'h03};
      vecs[2]  = '{16'h005A, 16'h100F, 16'h1430, 8'h3A, 1'b0, 8'h03};
      vecs[3]  = '{16'h0010, 16'h0C20, 16'h0805, 8'hF6, 1'b0, 8'h03};
      vecs[4]  = '{16'h0080, 16'h0480, 16'h0800, 8'h01, 1'b0, 8'h03};
      vecs[5]  = '{16'h00C3, 16'h18FF, 16'h1C0F, 8'hF0, 1'b0, 8'h03};
      vecs[6]  = '{16'h007F, 16'h0401, 16'hB420, 8'h80, 1'b0, 8'h20};
      vecs[7]  = '{16'h0000, 16'hA410, 16'h0055, 8'h00, 1'b0, 8'h10};
      vecs[8]  = '{16'h0005, 16'h0C05, 16'hBC20, 8'h00, 1'b0, 8'h20};
      vecs[9]  = '{16'h0080, 16'hAC30, 16'h0055, 8'h80, 1'b0, 8'h30};
      vecs[10] = '{16'h0011, 16'h6007, 16'h2007, 8'hC3, 1'b0, 8'h03};
      vecs[11] = '{16'h0042, 16'h6002, 16'h2402, 8'h84, 1'b0, 8'h03};
      vecs[12] = '{16'h00FF, 16'h0401, 16'h1000, 8'h00, 1'b1, 8'h03};

      // Reset state and two-cycle latency with a zero-wait fetch.
      fill_halt();
      imem[0] = 16'h005A;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_pc", {24'b0, pc_out}, 32'h0);
      check("rst_acc", {24'b0, acc_out}, 32'h0);
      check("rst_cy", {31'b0, flag_cy}, 32'h0);
      check("rst_imem_req", {31'b0, imem_req}, 32'h0);
      check("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("lat_acc", {24'b0, acc_out}, 32'h5A);
      check("lat_pc", {24'b0, pc_out}, 32'h1);

      // Short programs ending in HALT, with random fetch wait states.
      for (int v = 0; v < 13; v++) begin
         rst = 1'b1;
         fill_halt();
         imem[0] = vecs[v].i0;
         imem[1] = vecs[v].i1;
         imem[2] = vecs[v].i2;
         imem_wait = $urandom_range(0, 2);
         do_reset();
         sb.push_back('{vecs[v].acc, vecs[v].cy, vecs[v].pc});
         wait_halt($sformatf("vec%0d", v));
         e = sb.pop_front();
         check($sformatf("vec%0d_acc", v), {24'b0, acc_out}, {24'b0, e.acc});
         check($sformatf("vec%0d_cy", v), {31'b0, flag_cy}, {31'b0, e.cy});
         check($sformatf("vec%0d_pc", v), {24'b0, pc_out}, {24'b0, e.pc});
      end

      // Banked store and load through the data port with three wait states.
      rst = 1'b1;
      fill_halt();
      imem[0] = 16'hC002;
      imem[1] = 16'h0010;
      imem[2] = 16'h6001;
      imem[3] = 16'h0077;
      imem[4] = 16'h8001;
      imem[5] = 16'h0000;
      imem[6] = 16'h4001;
      imem_wait = 0;
      dmem_wait = 3;
      do_reset();
      wr_cyc = 0;
      rq_cyc = 0;
      for (int c = 0; c < 300 && !halted; c++) begin
         if (dmem_req) begin
            rq_cyc++;
            check("dmem_addr", {22'b0, dmem_addr}, 32'h210);
            if (dmem_we) begin
               wr_cyc++;
               check("dmem_wdata", {24'b0, dmem_wdata}, 32'h77);
            end
         end
         @(negedge clk);
      end
      check("mem_halted", {31'b0, halted}, 32'd1);
      check("st_req_cycles", wr_cyc, 32'd4);
      check("all_req_cycles", rq_cyc, 32'd8);
      check("ld_acc", {24'b0, acc_out}, 32'h77);
      check("ld_pc", {24'b0, pc_out}, 32'h7);
      dmem_wait = 0;

      // HALT at 0x05 stays quiet until reset.
      rst = 1'b1;
      fill_halt();
      for (int i = 0; i < 5; i++) imem[i] = 16'(i + 1);
      do_reset();
      wait_halt("halt5");
      check("halt_pc", {24'b0, pc_out}, 32'h5);
      check("halt_acc", {24'b0, acc_out}, 32'h5);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (imem_req || dmem_req || !halted) bad++;
      end
      check("halt_quiet", bad, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("halt_rst_halted", {31'b0, halted}, 32'd0);
      check("halt_rst_pc", {24'b0, pc_out}, 32'h0);
      rst = 1'b0;
      #1;
      check("refetch_req", {31'b0, imem_req}, 32'd1);
      check("refetch_addr", {24'b0, imem_addr}, 32'h0);

      // Reset abandons a fetch whose ack is withheld.
      rst = 1'b1;
      fill_halt();
      imem[0] = 16'h005A;
      imem[1] = 16'h0011;
      do_reset();
      wait_pc(8'h01, 1'b1, "hold");
      imem_hold = 1'b1;
      repeat (3) @(negedge clk);
      check("hold_req", {31'b0, imem_req}, 32'd1);
      check("hold_acc", {24'b0, acc_out}, 32'h5A);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abandon_req", {31'b0, imem_req}, 32'd0);
      check("abandon_pc", {24'b0, pc_out}, 32'h0);
      check("abandon_acc", {24'b0, acc_out}, 32'h0);
      imem_hold = 1'b0;

      // PC wraps from 0xFF to 0x00 after a non-jump.
      fill_halt();
      imem[0]   = 16'hA0FF;
      imem[255] = 16'h0033;
      do_reset();
      wait_pc(8'hFF, 1'b1, "wrap_to_ff");
      wait_pc(8'hFF, 1'b0, "wrap_from_ff");
      check("wrap_pc", {24'b0, pc_out}, 32'h0);
      check("wrap_acc", {24'b0, acc_out}, 32'h33);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
